// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access (MA) pipeline stage.
//  - funct3 load-type codes used by the load extender
//  - RAM access-size codes driven on o_data_rd_en_ctrl
//  - MA/WB pipeline register layout
//  - small helpers that sign/zero-extend a selected byte or half-word
package mem_access_stage_pkg;

  // Load funct3 encodings (RV32I).
  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  // Access size presented to the data RAM. Byte/half/word match funct3[1:0] of loads and stores,
  // so the stage can forward funct3[1:0] directly when an access is active.
  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeIdle = 2'b11
  } size_e;

  // MA/WB pipeline register contents.
  typedef struct packed {
    logic        mem_to_reg;
    logic [1:0]  rw_sel;
    logic        reg_wr;
    logic [4:0]  reg_dest;
    logic [31:0] pc_plus_4;
    logic [31:0] result;
    logic [2:0]  funct3;   // kept for load extension in the following cycle
    logic [1:0]  offset;   // byte offset within the word, alu_result[1:0]
  } ma_reg_t;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic is_signed);
    return {{24{is_signed & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic is_signed);
    return {{16{is_signed & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Load extender for the MA stage (purely combinational).
// Selects the byte or half-word addressed by the byte offset from a full RAM word and sign- or
// zero-extends it according to the load funct3. Unknown funct3 values pass the word through.
// Ports:
//   data_i    RAM read word
//   funct3_i  load type (registered copy from the MA/WB register)
//   offset_i  byte offset within the word (registered alu_result[1:0])
//   data_o    extended load result
module mem_access_stage_load_extend
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data_i[7:0];
    unique case (offset_i)
      2'd0: byte_sel = data_i[7:0];
      2'd1: byte_sel = data_i[15:8];
      2'd2: byte_sel = data_i[23:16];
      2'd3: byte_sel = data_i[31:24];
      default: byte_sel = data_i[7:0];
    endcase
  end

  // Half-word loads ignore offset bit 0; misalignment is not trapped.
  assign half_sel = offset_i[1] ? data_i[31:16] : data_i[15:0];

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      F3Lb:    data_o = ext_byte(byte_sel, 1'b1);
      F3Lbu:   data_o = ext_byte(byte_sel, 1'b0);
      F3Lh:    data_o = ext_half(half_sel, 1'b1);
      F3Lhu:   data_o = ext_half(half_sel, 1'b0);
      F3Lw:    data_o = data_i;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access (MA) stage of the RV32I pipeline, between EX and WB.
// Drives enable and access size for an external single-port, write-first, synchronous data RAM
// (address and write data are wired from EX straight to the RAM by the integrator), registers the
// EX results into the MA/WB register, and extends the RAM read word for WB.
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_clk_en              stage enable; 0 holds every register and gates the RAM enable
//   i_data_rd             RAM read word, returned one cycle after the request
//   i_ex_*                EX-stage results and controls (funct7 and store data are not used here)
//   o_data_rd_en_ctrl     RAM access size: 00 byte, 01 half, 10 word, 11 idle
//   o_ma_ram_en           RAM enable
//   o_ma_*                registered EX fields for WB
//   o_ma_read_data        extended load data, valid the cycle after the load request
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  input  logic [31:0] i_data_rd,
  input  logic        i_ex_mem_to_reg,
  input  logic [1:0]  i_ex_rw_sel,
  input  logic        i_ex_reg_wr,
  input  logic        i_ex_mem_rd,
  input  logic        i_ex_mem_wr,
  input  logic [31:0] i_ex_pc_plus_4,
  input  logic [31:0] i_ex_alu_result,
  input  logic [31:0] i_ex_reg_read_data2,
  input  logic [4:0]  i_ex_reg_dest,
  input  logic [2:0]  i_ex_funct3,
  input  logic [6:0]  i_ex_funct7,
  output logic [1:0]  o_data_rd_en_ctrl,
  output logic        o_ma_ram_en,
  output logic        o_ma_mem_to_reg,
  output logic [1:0]  o_ma_rw_sel,
  output logic [31:0] o_ma_pc_plus_4,
  output logic [31:0] o_ma_result,
  output logic [4:0]  o_ma_reg_dest,
  output logic        o_ma_reg_wr,
  output logic [31:0] o_ma_read_data
);

  logic    mem_access;
  ma_reg_t ma_d, ma_q;

  // Store data goes to the RAM outside this block; funct7 carries nothing for loads/stores.
  logic unused_inputs;
  assign unused_inputs = ^{i_ex_funct7, i_ex_reg_read_data2};

  // RAM control (combinational).
  assign mem_access        = i_ex_mem_rd | i_ex_mem_wr;
  assign o_ma_ram_en       = i_clk_en & mem_access;
  assign o_data_rd_en_ctrl = mem_access ? i_ex_funct3[1:0] : SizeIdle;

  // MA/WB register next state.
  always_comb begin
    ma_d = ma_q;
    if (i_clk_en) begin
      ma_d.mem_to_reg = i_ex_mem_to_reg;
      ma_d.rw_sel     = i_ex_rw_sel;
      ma_d.reg_wr     = i_ex_reg_wr;
      ma_d.reg_dest   = i_ex_reg_dest;
      ma_d.pc_plus_4  = i_ex_pc_plus_4;
      ma_d.result     = i_ex_alu_result;
      ma_d.funct3     = i_ex_funct3;
      ma_d.offset     = i_ex_alu_result[1:0];
    end
  end

  // Reset wins over the enable and drops whatever was in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ma_q <= '0;
    end else begin
      ma_q <= ma_d;
    end
  end

  assign o_ma_mem_to_reg = ma_q.mem_to_reg;
  assign o_ma_rw_sel     = ma_q.rw_sel;
  assign o_ma_reg_wr     = ma_q.reg_wr;
  assign o_ma_reg_dest   = ma_q.reg_dest;
  assign o_ma_pc_plus_4  = ma_q.pc_plus_4;
  assign o_ma_result     = ma_q.result;

  // RAM data arrives one cycle after the request, lining up with the registered funct3/offset.
  mem_access_stage_load_extend u_load_extend (
    .data_i   (i_data_rd),
    .funct3_i (ma_q.funct3),
    .offset_i (ma_q.offset),
    .data_o   (o_ma_read_data)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with a behavioural write-first single-port RAM.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [31:0] data_rd;
  logic        ex_mem_to_reg;
  logic [1:0]  ex_rw_sel;
  logic        ex_reg_wr;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [31:0] ex_pc_plus_4;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_reg_read_data2;
  logic [4:0]  ex_reg_dest;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [1:0]  data_rd_en_ctrl;
  logic        ma_ram_en;
  logic        ma_mem_to_reg;
  logic [1:0]  ma_rw_sel;
  logic [31:0] ma_pc_plus_4;
  logic [31:0] ma_result;
  logic [4:0]  ma_reg_dest;
  logic        ma_reg_wr;
  logic [31:0] ma_read_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  mem_access_stage dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_clk_en            (clk_en),
    .i_data_rd           (data_rd),
    .i_ex_mem_to_reg     (ex_mem_to_reg),
    .i_ex_rw_sel         (ex_rw_sel),
    .i_ex_reg_wr         (ex_reg_wr),
    .i_ex_mem_rd         (ex_mem_rd),
    .i_ex_mem_wr         (ex_mem_wr),
    .i_ex_pc_plus_4      (ex_pc_plus_4),
    .i_ex_alu_result     (ex_alu_result),
    .i_ex_reg_read_data2 (ex_reg_read_data2),
    .i_ex_reg_dest       (ex_reg_dest),
    .i_ex_funct3         (ex_funct3),
    .i_ex_funct7         (ex_funct7),
    .o_data_rd_en_ctrl   (data_rd_en_ctrl),
    .o_ma_ram_en         (ma_ram_en),
    .o_ma_mem_to_reg     (ma_mem_to_reg),
    .o_ma_rw_sel         (ma_rw_sel),
    .o_ma_pc_plus_4      (ma_pc_plus_4),
    .o_ma_result         (ma_result),
    .o_ma_reg_dest       (ma_reg_dest),
    .o_ma_reg_wr         (ma_reg_wr),
    .o_ma_read_data      (ma_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first single-port RAM, word addressed by alu_result[9:2].
  logic [31:0] ram_mem [256];
  always @(posedge clk) begin
    if (ma_ram_en) begin
      if (ex_mem_wr) begin
        ram_mem[ex_alu_result[9:2]] <= ex_reg_read_data2;
        data_rd <= ex_reg_read_data2;
      end else begin
        data_rd <= ram_mem[ex_alu_result[9:2]];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_mem_to_reg     = 1'b0;
    ex_rw_sel         = 2'd0;
    ex_reg_wr         = 1'b0;
    ex_mem_rd         = 1'b0;
    ex_mem_wr         = 1'b0;
    ex_pc_plus_4      = '0;
    ex_alu_result     = '0;
    ex_reg_read_data2 = '0;
    ex_reg_dest       = '0;
    ex_funct3         = '0;
    ex_funct7         = '0;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [31:0] wdata);
    idle_inputs();
    ex_mem_wr         = 1'b1;
    ex_alu_result     = addr;
    ex_reg_read_data2 = wdata;
    ex_funct3         = 3'b010;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] exp,
                            input string tag);
    idle_inputs();
    ex_mem_rd     = 1'b1;
    ex_mem_to_reg = 1'b1;
    ex_reg_wr     = 1'b1;
    ex_alu_result = addr;
    ex_funct3     = f3;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // Pop one scoreboard entry and compare with the load result of this cycle.
  task automatic drain_one();
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      check_eq(tag_q.pop_front(), ma_read_data, exp_q.pop_front());
    end
  endtask

  typedef struct {
    logic [1:0]  off;
    logic [2:0]  f3;
    logic [31:0] exp;
    string       tag;
  } ext_vec_t;

  initial begin
    ext_vec_t ext_vecs[8];
    ext_vecs[0] = '{2'd0, 3'b000, 32'hFFFF_FFFF, "lb_off0"};
    ext_vecs[1] = '{2'd0, 3'b100, 32'h0000_00FF, "lbu_off0"};
    ext_vecs[2] = '{2'd0, 3'b001, 32'hFFFF_F0FF, "lh_off0"};
    ext_vecs[3] = '{2'd0, 3'b101, 32'h0000_F0FF, "lhu_off0"};
    ext_vecs[4] = '{2'd2, 3'b001, 32'hFFFF_8000, "lh_off2"};
    ext_vecs[5] = '{2'd0, 3'b010, 32'h8000_F0FF, "lw_off0"};
    ext_vecs[6] = '{2'd1, 3'b000, 32'hFFFF_FFF0, "lb_off1"};
    ext_vecs[7] = '{2'd3, 3'b100, 32'h0000_0080, "lbu_off3"};

    rst    = 1'b1;
    clk_en = 1'b1;
    idle_inputs();
    repeat (3) tick();

    // Reset state.
    check_eq("rst_mem_to_reg", {31'd0, ma_mem_to_reg}, 32'd0);
    check_eq("rst_rw_sel", {30'd0, ma_rw_sel}, 32'd0);
    check_eq("rst_pc_plus_4", ma_pc_plus_4, 32'd0);
    check_eq("rst_result", ma_result, 32'd0);
    check_eq("rst_reg_dest", {27'd0, ma_reg_dest}, 32'd0);
    check_eq("rst_reg_wr", {31'd0, ma_reg_wr}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("idle_size", {30'd0, data_rd_en_ctrl}, 32'd3);
    check_eq("idle_ram_en", {31'd0, ma_ram_en}, 32'd0);
    tick();
    check_eq("post_rst_pc", ma_pc_plus_4, 32'd0);

    // Word stores.
    for (int i = 0; i < 10; i++) begin
      drive_store(32'h20 + 32'(4 * i), 32'h41 + 32'(i));
      #1;
      if (i == 0) begin
        check_eq("st_ram_en", {31'd0, ma_ram_en}, 32'd1);
        check_eq("st_size", {30'd0, data_rd_en_ctrl}, 32'd2);
      end
      tick();
    end

    // Byte loads, back to back; each result checked one edge after its request.
    for (int i = 0; i < 10; i++) begin
      drive_load(32'h20 + 32'(4 * i), 3'b000, 32'h41 + 32'(i), $sformatf("ld%0d", i));
      #1;
      if (i == 0) check_eq("ld_size", {30'd0, data_rd_en_ctrl}, 32'd0);
      tick();
      drain_one();
      if (i == 0) check_eq("ld_mem_to_reg", {31'd0, ma_mem_to_reg}, 32'd1);
    end

    // Sign/zero extension on 0x8000F0FF at 0x80.
    drive_store(32'h80, 32'h8000_F0FF);
    tick();
    foreach (ext_vecs[k]) begin
      drive_load(32'h80 + 32'(ext_vecs[k].off), ext_vecs[k].f3, ext_vecs[k].exp, ext_vecs[k].tag);
      tick();
      drain_one();
    end

    // Pass-through of EX fields.
    idle_inputs();
    ex_pc_plus_4  = 32'h104;
    ex_alu_result = 32'h55;
    ex_reg_dest   = 5'd7;
    ex_reg_wr     = 1'b1;
    ex_rw_sel     = 2'd2;
    tick();
    check_eq("pt_pc_plus_4", ma_pc_plus_4, 32'h104);
    check_eq("pt_result", ma_result, 32'h55);
    check_eq("pt_reg_dest", {27'd0, ma_reg_dest}, 32'd7);
    check_eq("pt_reg_wr", {31'd0, ma_reg_wr}, 32'd1);
    check_eq("pt_rw_sel", {30'd0, ma_rw_sel}, 32'd2);
    check_eq("pt_mem_to_reg", {31'd0, ma_mem_to_reg}, 32'd0);

    // Stall: inputs change, registers hold, RAM disabled.
    clk_en        = 1'b0;
    ex_pc_plus_4  = 32'h999;
    ex_alu_result = 32'h1234;
    ex_reg_dest   = 5'd20;
    ex_reg_wr     = 1'b0;
    ex_rw_sel     = 2'd1;
    ex_mem_rd     = 1'b1;
    #1;
    check_eq("stall_ram_en", {31'd0, ma_ram_en}, 32'd0);
    repeat (2) tick();
    check_eq("stall_pc_plus_4", ma_pc_plus_4, 32'h104);
    check_eq("stall_result", ma_result, 32'h55);
    check_eq("stall_reg_dest", {27'd0, ma_reg_dest}, 32'd7);
    check_eq("stall_reg_wr", {31'd0, ma_reg_wr}, 32'd1);
    check_eq("stall_rw_sel", {30'd0, ma_rw_sel}, 32'd2);

    // Mid-sequence synchronous reset.
    clk_en = 1'b1;
    idle_inputs();
    ex_pc_plus_4  = 32'h200;
    ex_alu_result = 32'h300;
    ex_reg_dest   = 5'd9;
    ex_reg_wr     = 1'b1;
    tick();
    check_eq("pre_rst_pc", ma_pc_plus_4, 32'h200);
    rst          = 1'b1;
    ex_pc_plus_4 = 32'h204;
    #1;
    check_eq("rst_not_yet_pc", ma_pc_plus_4, 32'h200);
    check_eq("rst_not_yet_dest", {27'd0, ma_reg_dest}, 32'd9);
    tick();
    check_eq("rst_mid_pc", ma_pc_plus_4, 32'd0);
    check_eq("rst_mid_result", ma_result, 32'd0);
    check_eq("rst_mid_dest", {27'd0, ma_reg_dest}, 32'd0);
    check_eq("rst_mid_reg_wr", {31'd0, ma_reg_wr}, 32'd0);
    rst = 1'b0;
    tick();

    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MA) stage of the RV32I pipeline, between execute (EX) and write-back (WB). It drives the enable and access size for an external single-port, write-first, synchronous data RAM, and registers the EX results into the MA/WB pipeline register. It also sign- or zero-extends load data returned by the RAM for WB.

## Interface
No parameters.
- i_clk  in  1  single clock; everything updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_clk_en  in  1  stage enable; when 0, all registers hold.
- i_data_rd  in  32  RAM read data, already registered by the RAM, one cycle after the request.
- i_ex_mem_to_reg  in  1  WB selects memory data.
- i_ex_rw_sel  in  2  WB result-select code, passed through unchanged.
- i_ex_reg_wr  in  1  register-file write enable.
- i_ex_mem_rd  in  1  load request.
- i_ex_mem_wr  in  1  store request.
- i_ex_pc_plus_4  in  32  PC+4 of the instruction.
- i_ex_alu_result  in  32  ALU result / effective address.
- i_ex_reg_read_data2  in  32  store data (wired to the RAM by the integrator).
- i_ex_reg_dest  in  5  destination register.
- i_ex_funct3  in  3  load/store type.
- i_ex_funct7  in  7  ignored.
- o_data_rd_en_ctrl  out  2  access size to RAM: 00 byte, 01 half, 10 word, 11 idle.
- o_ma_ram_en  out  1  RAM enable.
- o_ma_mem_to_reg, o_ma_rw_sel, o_ma_pc_plus_4, o_ma_result, o_ma_reg_dest, o_ma_reg_wr  out  1/2/32/32/5/1  registered copies of the matching EX inputs (o_ma_result holds the ALU result).
- o_ma_read_data  out  32  extended load data.

## Operation
- o_ma_ram_en = i_clk_en & (i_ex_mem_rd | i_ex_mem_wr). Combinational.
- o_data_rd_en_ctrl = i_ex_funct3[1:0] when i_ex_mem_rd | i_ex_mem_wr, else 2'b11. Combinational.
- RAM address is i_ex_alu_result and write data is i_ex_reg_read_data2, wired straight to the RAM.
- Pipeline register: on each edge with i_clk_en=1, capture all EX control/data fields, plus funct3 and alu_result[1:0] for load extension.
- o_ma_read_data is combinational from i_data_rd, using the registered funct3 (f) and offset (a):
  - f=000 LB: sign-extend byte at bit position a*8.
  - f=100 LBU: zero-extend byte at bit position a*8.
  - f=001 LH: sign-extend half at bit position a[1]*16.
  - f=101 LHU: zero-extend half at bit position a[1]*16.
  - f=010 LW, and any other value: pass i_data_rd unchanged.
- Misaligned accesses are not trapped. LH/LHU ignore a[0]; LW ignores a[1:0].

## Timing
- Reset: all registered outputs and internal registers are 0. Reset takes priority over i_clk_en. Asserting reset mid-transfer discards the in-flight stage contents.
- Outputs: o_ma_* are valid one cycle after EX presents. o_ma_read_data is valid in the same cycle, aligned with RAM read latency 1.
- Stall: with i_clk_en=0, registered outputs hold and o_ma_ram_en=0.
- Simultaneous i_ex_mem_rd and i_ex_mem_wr: o_ma_ram_en=1. The RAM's write-first behaviour returns the new data.

## Structure
- Shared package holds the funct3 load-type constants (LB/LH/LW/LBU/LHU) and the size codes (BYTE/HALF/WORD/IDLE).
- Sub-module load_extend: combinational; inputs data, funct3 and offset; output is the extended word.
- The data RAM (rams_sp_wf) stays outside this block.

## Test plan
- Reset held, then released: every o_ma_* is 0. With no access, o_data_rd_en_ctrl=11 and o_ma_ram_en=0.
- Store then load, word data:
  - Store words 0x41..0x4A to addresses 0x20, 0x24, …, 0x44 with funct3=010.
  - Read them back with funct3=000.
  - One edge after each read request, o_ma_read_data = 0x00000041..0x0000004A.
- Sign/zero extension: RAM word 0x8000F0FF at offset 0:
  - LB → 0xFFFFFFFF; LBU → 0x000000FF.
  - LH → 0xFFFFF0FF; LHU → 0x0000F0FF.
  - LH at offset 2 → 0xFFFF8000.
  - LW → 0x8000F0FF.
- Pass-through: present pc_plus_4=0x104, alu_result=0x55, reg_dest=7, reg_wr=1, rw_sel=2. After one edge, the corresponding o_ma_* outputs carry these values.
- Stall: i_clk_en=0 while inputs change → outputs hold their previous values and o_ma_ram_en=0.
- Synchronous reset asserted mid-sequence → outputs are 0 after the next edge, not before it.
